fact_operand_feeder: RTL and testbench
======================================

FACT_OPERAND_FEEDER -- requirements
Module: fact_operand_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning operand FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter MAX_N, default 12, meaning the largest operand forwarded (12! is the largest factorial that fits in 32 bits).
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream operand valid.
REQ-006 SHALL have port in_n, input, 4, upstream operand.
REQ-007 SHALL have port in_ready, output, 1, feeder can accept in_n this cycle.
REQ-008 SHALL have port sweep_start, input, 1, single-cycle request to sweep n = 0..limit.
REQ-009 SHALL have port sweep_limit, input, 4, last operand of a sweep, sampled on sweep_start.
REQ-010 SHALL have port busy, output, 1, sweep in progress.
REQ-011 SHALL have port n, output, 4, operand to the factorial stage.
REQ-012 SHALL have port n_valid, output, 1, n is valid.
REQ-013 SHALL have port n_ready, input, 1, factorial stage accepts n.
REQ-014 SHALL have port err_range, output, 1, one-cycle pulse on a rejected operand.
REQ-015 SHALL have port drop_cnt, output, 8, count of rejected operands.

Function
REQ-016 SHALL implement states IDLE (FIFO mode) and SWEEP.
REQ-017 SHALL complete an input handshake when in_valid && in_ready; in_ready = (state==IDLE) && (FIFO not full).
REQ-018 SHALL, on an accepted in_n > MAX_N, not store it, pulse err_range in the following cycle, and increment drop_cnt, saturating at 255.
REQ-019 SHALL complete an output handshake when n_valid && n_ready; n and n_valid SHALL be registered.
REQ-020 SHALL hold n stable while n_valid && !n_ready.
REQ-021 SHALL, in IDLE, assert n_valid whenever the FIFO is non-empty, with n equal to the oldest entry.
REQ-022 SHALL present an operand pushed into an empty FIFO on n one cycle after acceptance.
REQ-023 SHALL keep the occupancy unchanged on a simultaneous push and pop, and preserve FIFO order.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; a full FIFO deasserts in_ready and loses no data.
REQ-025 SHALL transition IDLE->SWEEP on sweep_start only when the FIFO is empty and n_valid is low; otherwise sweep_start SHALL be ignored.
REQ-026 SHALL, on entering SWEEP, latch limit = min(sweep_limit, MAX_N), set busy, and present n=0 with n_valid=1 the next cycle.
REQ-027 SHALL advance n by 1 on each output handshake in SWEEP; the handshake with n==limit SHALL return to IDLE, drop n_valid and clear busy in the next cycle.
REQ-028 SHALL ignore sweep_start while in SWEEP and hold in_ready low for the whole sweep.

Reset
REQ-029 SHALL, while reset==0 at a clk edge, force state=IDLE, empty the FIFO, and drive n=0, n_valid=0, in_ready=0, busy=0, err_range=0, drop_cnt=0.
REQ-030 SHALL abandon any sweep or FIFO contents on mid-operation reset; in_ready SHALL rise the first cycle after reset is released.

Verification
REQ-031 SHALL be verified by: push 3,5,7 with n_ready=1 -> n=3,5,7 on consecutive cycles, first one cycle after the first push.
REQ-032 SHALL be verified by: n_ready=0, push 4 operands -> in_ready=0 after the 4th; raise n_ready -> all 4 are delivered in order with none lost.
REQ-033 SHALL be verified by: push 13 then 15 -> neither is emitted, err_range pulses twice and drop_cnt=2; 256 rejects leave drop_cnt=255.
REQ-034 SHALL be verified by: sweep_start with sweep_limit=3 and n_ready=1 -> n=0,1,2,3 with busy high throughout, then IDLE; sweep_limit=15 -> sweep ends at n=12.
REQ-035 SHALL be verified by: sweep_start while the FIFO holds one entry -> no sweep occurs and the entry is delivered normally.
REQ-036 SHALL be verified by: reset asserted at n=2 of a sweep -> the next cycle has n_valid=0 and busy=0; after release in_ready=1 and the FIFO is empty.

Source files
------------

// File: rtl/fact_operand_feeder.sv
// Operand feeder for the factorial stage: FIFO of upstream operands, or a 0..limit sweep.
// Latency: an operand pushed into an empty FIFO appears on n one cycle after acceptance.
// Backpressure: n/n_valid are held while n_ready is low; in_ready drops when full or sweeping.
module fact_operand_feeder #(
    parameter int DEPTH = 4,
    parameter int MAX_N = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] in_n,
    output logic       in_ready,
    input  logic       sweep_start,
    input  logic [3:0] sweep_limit,
    output logic       busy,
    output logic [3:0] n,
    output logic       n_valid,
    input  logic       n_ready,
    output logic       err_range,
    output logic [7:0] drop_cnt
);

    typedef enum logic {IDLE, SWEEP} state_t;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [3:0]    MAXN = 4'(MAX_N);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t        state, state_nx;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nx;
    logic [CW-1:0] count, count_nx, remain;
    logic [3:0]    limit, head_nx;
    logic          accept, push, pop, reject, out_hs, go_sweep, sweep_done;

    // The output register counts as one of the DEPTH slots: n always mirrors the FIFO head.
    assign in_ready   = reset && (state == IDLE) && (count != FULL);
    assign accept     = in_valid && in_ready;
    assign push       = accept && (in_n <= MAXN);
    assign reject     = accept && (in_n > MAXN);
    assign out_hs     = n_valid && n_ready;
    assign pop        = out_hs && (state == IDLE);
    // A push in the same cycle makes the FIFO non-empty, so it takes precedence over a sweep.
    assign go_sweep   = (state == IDLE) && sweep_start && (count == '0) && !n_valid && !push;
    assign sweep_done = (state == SWEEP) && out_hs && (n == limit);
    assign busy       = (state == SWEEP);

    // Next-state logic for the IDLE/SWEEP controller.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go_sweep)   state_nx = SWEEP;
            SWEEP:   if (sweep_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Head of the FIFO after this cycle's push/pop; a push into an otherwise empty FIFO bypasses mem.
    always_comb begin
        rd_nx    = rd_ptr + AW'(pop);
        count_nx = count + CW'(push) - CW'(pop);
        remain   = count - CW'(pop);
        head_nx  = (remain == '0) ? in_n : mem[rd_nx];
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // FIFO storage; contents need no reset because count gates their visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_n;
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_nx;
            count  <= count_nx;
        end
    end

    // Registered operand output: FIFO head in IDLE, incrementing counter in SWEEP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            n       <= '0;
            n_valid <= 1'b0;
            limit   <= '0;
        end else if (state == IDLE) begin
            if (go_sweep) begin
                n       <= '0;
                n_valid <= 1'b1;
                limit   <= (sweep_limit > MAXN) ? MAXN : sweep_limit;
            end else begin
                n_valid <= (count_nx != '0);
                if (count_nx != '0) n <= head_nx;
            end
        end else if (out_hs) begin
            if (n == limit) n_valid <= 1'b0;
            else            n <= n + 4'd1;
        end
    end

    // Out-of-range reporting: one-cycle pulse and a saturating drop counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_range <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            err_range <= reject;
            if (reject && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_fact_operand_feeder.sv
module tb_fact_operand_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_n;
    logic       in_ready;
    logic       sweep_start;
    logic [3:0] sweep_limit;
    logic       busy;
    logic [3:0] n;
    logic       n_valid;
    logic       n_ready;
    logic       err_range;
    logic [7:0] drop_cnt;

    int tests = 0;
    int fails = 0;

    fact_operand_feeder #(.DEPTH(4), .MAX_N(12)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_n(in_n), .in_ready(in_ready),
        .sweep_start(sweep_start), .sweep_limit(sweep_limit), .busy(busy),
        .n(n), .n_valid(n_valid), .n_ready(n_ready),
        .err_range(err_range), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_n = '0; sweep_start = 1'b0;
        sweep_limit = '0; n_ready = 1'b0;
        tick(); tick();
        tests++; if (n_valid !== 1'b0)  begin fails++; $display("FAIL reset_n_valid got %0b want 0", n_valid); end
        tests++; if (n !== 4'd0)        begin fails++; $display("FAIL reset_n got %0d want 0", n); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
        tests++; if (err_range !== 1'b0) begin fails++; $display("FAIL reset_err got %0b want 0", err_range); end
        tests++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        reset = 1'b1;
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_stream();
        logic [3:0] exp [3] = '{4'd3, 4'd5, 4'd7};
        n_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_n = exp[i];
            tick();
            tests++; if (n_valid !== 1'b1 || n !== exp[i]) begin fails++; $display("FAIL stream_%0d got n=%0d v=%0b want n=%0d v=1", i, n, n_valid, exp[i]); end
        end
        in_valid = 1'b0;
        tick();
        tests++; if (n_valid !== 1'b0) begin fails++; $display("FAIL stream_drain got v=%0b want 0", n_valid); end
    endtask

    task automatic test_full();
        logic [3:0] exp [4] = '{4'd4, 4'd1, 4'd2, 4'd9};
        n_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_%0d got %0b want 1", i, in_ready); end
            in_n = exp[i];
            tick();
        end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got %0b want 0", in_ready); end
        // Offered while full: must not be taken.
        in_n = 4'd6;
        tick();
        tests++; if (n !== 4'd4 || n_valid !== 1'b1) begin fails++; $display("FAIL full_hold got n=%0d v=%0b want n=4 v=1", n, n_valid); end
        in_valid = 1'b0;
        n_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (n !== exp[i] || n_valid !== 1'b1) begin fails++; $display("FAIL full_out_%0d got n=%0d v=%0b want n=%0d v=1", i, n, n_valid, exp[i]); end
            tick();
        end
        tests++; if (n_valid !== 1'b0) begin fails++; $display("FAIL full_empty got v=%0b want 0", n_valid); end
    endtask

    task automatic test_reject();
        n_ready = 1'b1;
        in_valid = 1'b1;
        in_n = 4'd13;
        tick();
        tests++; if (err_range !== 1'b1 || drop_cnt !== 8'd1 || n_valid !== 1'b0) begin fails++; $display("FAIL rej_13 got err=%0b drop=%0d v=%0b want 1 1 0", err_range, drop_cnt, n_valid); end
        in_n = 4'd15;
        tick();
        tests++; if (err_range !== 1'b1 || drop_cnt !== 8'd2 || n_valid !== 1'b0) begin fails++; $display("FAIL rej_15 got err=%0b drop=%0d v=%0b want 1 2 0", err_range, drop_cnt, n_valid); end
        in_valid = 1'b0;
        tick();
        tests++; if (err_range !== 1'b0) begin fails++; $display("FAIL rej_pulse_end got %0b want 0", err_range); end
        in_valid = 1'b1;
        in_n = 4'd14;
        for (int i = 0; i < 256; i++) tick();
        in_valid = 1'b0;
        tick();
        tests++; if (drop_cnt !== 8'd255) begin fails++; $display("FAIL rej_saturate got %0d want 255", drop_cnt); end
        tests++; if (n_valid !== 1'b0) begin fails++; $display("FAIL rej_nothing_out got v=%0b want 0", n_valid); end
    endtask

    task automatic test_sweep();
        n_ready = 1'b1;
        sweep_limit = 4'd3;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            tests++; if (n !== 4'(k) || n_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL sweep3_%0d got n=%0d v=%0b busy=%0b rdy=%0b want n=%0d 1 1 0", k, n, n_valid, busy, in_ready, k); end
            // A second request mid-sweep must be ignored.
            sweep_start = (k == 1);
            sweep_limit = 4'd0;
            tick();
            sweep_start = 1'b0;
        end
        tests++; if (n_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL sweep3_end got v=%0b busy=%0b rdy=%0b want 0 0 1", n_valid, busy, in_ready); end

        sweep_limit = 4'd15;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            tests++; if (n !== 4'(k) || n_valid !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL sweep15_%0d got n=%0d v=%0b busy=%0b want n=%0d 1 1", k, n, n_valid, busy, k); end
            if (k == 5) begin
                n_ready = 1'b0;
                tick(); tick();
                tests++; if (n !== 4'd5 || n_valid !== 1'b1) begin fails++; $display("FAIL sweep_stall got n=%0d v=%0b want n=5 v=1", n, n_valid); end
                n_ready = 1'b1;
            end
            tick();
        end
        tests++; if (n_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL sweep15_end got v=%0b busy=%0b want 0 0", n_valid, busy); end
    endtask

    task automatic test_sweep_blocked();
        n_ready = 1'b0;
        in_valid = 1'b1;
        in_n = 4'd8;
        tick();
        in_valid = 1'b0;
        sweep_limit = 4'd3;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        tests++; if (busy !== 1'b0 || n !== 4'd8 || n_valid !== 1'b1) begin fails++; $display("FAIL blocked_hold got busy=%0b n=%0d v=%0b want 0 8 1", busy, n, n_valid); end
        n_ready = 1'b1;
        tick();
        tests++; if (busy !== 1'b0 || n_valid !== 1'b0) begin fails++; $display("FAIL blocked_end got busy=%0b v=%0b want 0 0", busy, n_valid); end
    endtask

    task automatic test_reset_mid();
        n_ready = 1'b1;
        sweep_limit = 4'd5;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        tick(); tick();
        tests++; if (n !== 4'd2 || busy !== 1'b1) begin fails++; $display("FAIL mid_pre got n=%0d busy=%0b want 2 1", n, busy); end
        reset = 1'b0;
        tick();
        tests++; if (n_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL mid_reset got v=%0b busy=%0b rdy=%0b want 0 0 0", n_valid, busy, in_ready); end
        tests++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL mid_reset_drop got %0d want 0", drop_cnt); end
        reset = 1'b1;
        tick();
        tests++; if (in_ready !== 1'b1 || n_valid !== 1'b0) begin fails++; $display("FAIL mid_release got rdy=%0b v=%0b want 1 0", in_ready, n_valid); end
        in_valid = 1'b1;
        in_n = 4'd6;
        tick();
        in_valid = 1'b0;
        tests++; if (n !== 4'd6 || n_valid !== 1'b1) begin fails++; $display("FAIL mid_push got n=%0d v=%0b want 6 1", n, n_valid); end
        tick();
        tests++; if (n_valid !== 1'b0) begin fails++; $display("FAIL mid_only_entry got v=%0b want 0", n_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_reject();
        test_sweep();
        test_sweep_blocked();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
